// File: rtl/antares_port_arbiter.sv
// rtl/antares_port_arbiter.sv - two-port (instruction/data) arbiter onto one shared memory port
module antares_port_arbiter #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] iport_address,
    input  logic [3:0]  iport_wr,
    input  logic        iport_enable,
    output logic [31:0] iport_data_i,
    output logic        iport_ready,
    output logic        iport_error,
    input  logic [31:0] dport_address,
    input  logic [31:0] dport_data_o,
    input  logic [3:0]  dport_wr,
    input  logic        dport_enable,
    output logic [31:0] dport_data_i,
    output logic        dport_ready,
    output logic        dport_error,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data_o,
    output logic [3:0]  mem_wr,
    output logic        mem_enable,
    input  logic [31:0] mem_data_i,
    input  logic        mem_ready,
    input  logic        mem_error
);

    localparam int CW   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam int TLIM = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

    state_t          state;
    logic            last_d;     // 1: data port held the last grant, 0: instruction port
    logic [CW-1:0]   counter;

    logic in_busy;
    logic sel_d;
    logic own_enable;
    logic other_enable;
    logic completion;
    logic timeout_hit;
    logic aborted;

    // Decode the current grant and the events that end a transfer this cycle
    always_comb begin
        in_busy      = (state == BUSY_I) || (state == BUSY_D);
        sel_d        = (state == BUSY_D);
        own_enable   = sel_d ? dport_enable : iport_enable;
        other_enable = sel_d ? iport_enable : dport_enable;
        completion   = in_busy && (mem_ready || mem_error);
        // A dropped request wins over the timeout: an aborted transfer reports nothing
        timeout_hit  = in_busy && (TIMEOUT != 0) && own_enable && !completion
                       && (counter == CW'(TLIM));
        aborted      = in_busy && !own_enable && !completion;
    end

    // Route the granted port onto the memory bus and memory responses back to it
    always_comb begin
        mem_enable  = in_busy && own_enable && !timeout_hit;
        mem_address = 32'h0;
        mem_wr      = 4'h0;
        mem_data_o  = 32'h0;
        if (state == BUSY_I) begin
            mem_address = iport_address;
            mem_wr      = iport_wr;
        end else if (state == BUSY_D) begin
            mem_address = dport_address;
            mem_wr      = dport_wr;
            mem_data_o  = dport_data_o;
        end
        iport_ready  = (state == BUSY_I) && mem_ready;
        iport_error  = (state == BUSY_I) && (mem_error || timeout_hit);
        dport_ready  = (state == BUSY_D) && mem_ready;
        dport_error  = (state == BUSY_D) && (mem_error || timeout_hit);
        iport_data_i = mem_data_i;
        dport_data_i = mem_data_i;
    end

    // Grant FSM: round-robin on ties, hand over without a bubble when the other port waits
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            last_d  <= 1'b0;
            counter <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (dport_enable && (!iport_enable || !last_d)) begin
                        state   <= BUSY_D;
                        last_d  <= 1'b1;
                        counter <= '0;
                    end else if (iport_enable) begin
                        state   <= BUSY_I;
                        last_d  <= 1'b0;
                        counter <= '0;
                    end
                end
                BUSY_I, BUSY_D: begin
                    if (completion || timeout_hit || aborted) begin
                        if (other_enable) begin
                            state   <= sel_d ? BUSY_I : BUSY_D;
                            last_d  <= !sel_d;
                            counter <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (TIMEOUT != 0) begin
                        counter <= counter + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_antares_port_arbiter.sv
// tb/tb_antares_port_arbiter.sv - directed and randomized checks of antares_port_arbiter against a reference model
module tb_antares_port_arbiter;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] iport_address;
    logic [3:0]  iport_wr;
    logic        iport_enable;
    logic [31:0] iport_data_i;
    logic        iport_ready;
    logic        iport_error;
    logic [31:0] dport_address;
    logic [31:0] dport_data_o;
    logic [3:0]  dport_wr;
    logic        dport_enable;
    logic [31:0] dport_data_i;
    logic        dport_ready;
    logic        dport_error;
    logic [31:0] mem_address;
    logic [31:0] mem_data_o;
    logic [3:0]  mem_wr;
    logic        mem_enable;
    logic [31:0] mem_data_i;
    logic        mem_ready;
    logic        mem_error;

    always #5 clk = ~clk;

    antares_port_arbiter #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .iport_address(iport_address), .iport_wr(iport_wr), .iport_enable(iport_enable),
        .iport_data_i(iport_data_i), .iport_ready(iport_ready), .iport_error(iport_error),
        .dport_address(dport_address), .dport_data_o(dport_data_o), .dport_wr(dport_wr),
        .dport_enable(dport_enable), .dport_data_i(dport_data_i), .dport_ready(dport_ready),
        .dport_error(dport_error),
        .mem_address(mem_address), .mem_data_o(mem_data_o), .mem_wr(mem_wr),
        .mem_enable(mem_enable), .mem_data_i(mem_data_i), .mem_ready(mem_ready),
        .mem_error(mem_error)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: which port owns the memory (0 none, 1 instruction, 2 data),
    // who owned it last, and how many stalled cycles the current owner has spent
    int m_owner;
    int m_last;
    int m_waited;

    logic        e_men, e_ir, e_ie, e_dr, e_de, e_done;
    logic [3:0]  e_wr;
    logic [31:0] e_addr, e_wdata;

    logic        o_men, o_ir, o_ie, o_dr, o_de;
    logic [31:0] o_addr;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_expect();
        logic own_en, responded, timed_out;
        own_en    = (m_owner == 2) ? dport_enable : iport_enable;
        responded = (m_owner != 0) && (mem_ready || mem_error);
        timed_out = (m_owner != 0) && own_en && !responded && (m_waited == TIMEOUT - 1);
        e_men   = (m_owner != 0) && own_en && !timed_out;
        e_addr  = (m_owner == 1) ? iport_address : (m_owner == 2) ? dport_address : 32'h0;
        e_wr    = (m_owner == 1) ? iport_wr : (m_owner == 2) ? dport_wr : 4'h0;
        e_wdata = (m_owner == 2) ? dport_data_o : 32'h0;
        e_ir    = (m_owner == 1) && mem_ready;
        e_ie    = (m_owner == 1) && (mem_error || timed_out);
        e_dr    = (m_owner == 2) && mem_ready;
        e_de    = (m_owner == 2) && (mem_error || timed_out);
        e_done  = responded || timed_out || !own_en;
    endtask

    task automatic model_grant(input int p);
        m_owner  = p;
        m_last   = p;
        m_waited = 0;
    endtask

    task automatic model_advance();
        int other;
        logic other_en;
        if (rst) begin
            m_owner = 0; m_last = 1; m_waited = 0;
        end else if (m_owner == 0) begin
            if (dport_enable && iport_enable) model_grant((m_last == 1) ? 2 : 1);
            else if (dport_enable)            model_grant(2);
            else if (iport_enable)            model_grant(1);
        end else begin
            other    = (m_owner == 1) ? 2 : 1;
            other_en = (other == 2) ? dport_enable : iport_enable;
            if (e_done) begin
                if (other_en) model_grant(other);
                else          m_owner = 0;
            end else begin
                m_waited++;
            end
        end
    endtask

    // One bus cycle: inputs already applied just after the previous edge
    task automatic cycle();
        #1;
        model_expect();
        check("mem_bus", {mem_enable, mem_wr, mem_address, mem_data_o},
                         {e_men, e_wr, e_addr, e_wdata});
        check("port_resp", {iport_ready, iport_error, dport_ready, dport_error, iport_data_i, dport_data_i},
                           {e_ir, e_ie, e_dr, e_de, mem_data_i, mem_data_i});
        o_men = mem_enable; o_addr = mem_address;
        o_ir = iport_ready; o_ie = iport_error; o_dr = dport_ready; o_de = dport_error;
        @(posedge clk);
        model_advance();
        #1;
    endtask

    initial begin
        int ierr_at;
        logic men_at_err;
        int p_ready;

        rst = 1'b1;
        iport_address = 32'h0000_1000; iport_wr = 4'h0; iport_enable = 1'b0;
        dport_address = 32'h0000_0040; dport_data_o = 32'hDEAD_BEEF; dport_wr = 4'hF;
        dport_enable = 1'b0; mem_data_i = 32'h1234_5678; mem_ready = 1'b0; mem_error = 1'b0;
        @(posedge clk); #1;
        m_owner = 0; m_last = 1; m_waited = 0;
        rst = 1'b0;
        check("reset_outputs", {mem_enable, mem_wr, mem_address, mem_data_o,
                                iport_ready, iport_error, dport_ready, dport_error}, '0);
        cycle();

        // Single zero-wait data write
        dport_enable = 1'b1; mem_ready = 1'b1;
        cycle();
        check("dwrite_req_cycle_men", o_men, 1'b0);
        cycle();
        check("dwrite_men", o_men, 1'b1);
        check("dwrite_ready", {o_dr, o_ir, o_de}, 3'b100);
        dport_enable = 1'b0; mem_ready = 1'b0;
        cycle();

        // Both ports requesting out of reset with an always-ready memory
        rst = 1'b1; cycle(); rst = 1'b0;
        iport_enable = 1'b1; dport_enable = 1'b1; mem_ready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            cycle();
            check("alternate_d", o_dr, logic'((k % 2) == 1));
            check("alternate_i", o_ir, logic'(k > 0 && (k % 2) == 0));
        end
        iport_enable = 1'b0; dport_enable = 1'b0; mem_ready = 1'b0;
        cycle(); cycle();

        // Instruction fetch to a memory that never answers
        iport_enable = 1'b1; ierr_at = 0; men_at_err = 1'b1;
        cycle();
        for (int k = 1; k <= 20; k++) begin
            cycle();
            if (o_ie && ierr_at == 0) begin
                ierr_at = k;
                men_at_err = o_men;
            end
        end
        check("timeout_cycle", ierr_at, 16);
        check("timeout_men", men_at_err, 1'b0);
        iport_enable = 1'b0;
        cycle(); cycle();

        // Data transfer ends with ready and error together while fetch waits
        dport_enable = 1'b1; iport_enable = 1'b1;
        cycle();
        mem_ready = 1'b1; mem_error = 1'b1;
        cycle();
        check("both_resp_d", {o_dr, o_de, o_ir, o_ie}, 4'b1100);
        dport_enable = 1'b0; mem_ready = 1'b0; mem_error = 1'b0;
        cycle();
        check("handover_i", {o_men, o_addr}, {1'b1, iport_address});
        mem_ready = 1'b1;
        cycle();
        iport_enable = 1'b0; mem_ready = 1'b0;
        cycle();

        // Data port gives up in its second stalled cycle while fetch waits
        dport_enable = 1'b1; iport_enable = 1'b1;
        cycle();
        cycle();
        dport_enable = 1'b0;
        cycle();
        check("abort_d", {o_men, o_dr, o_de}, 3'b000);
        cycle();
        check("abort_handover_i", {o_men, o_addr}, {1'b1, iport_address});
        mem_ready = 1'b1;
        cycle();
        iport_enable = 1'b0; mem_ready = 1'b0;
        cycle();

        // Reset during an instruction transfer
        iport_enable = 1'b1;
        cycle(); cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0; dport_enable = 1'b1;
        cycle();
        check("post_reset_idle", {o_men, o_addr, o_ir, o_ie, o_dr, o_de}, '0);
        cycle();
        check("post_reset_grant_d", {o_men, o_addr}, {1'b1, dport_address});
        iport_enable = 1'b0; dport_enable = 1'b0;
        cycle(); cycle();

        // Randomized traffic: cores hold requests until answered, sometimes give up
        for (int k = 0; k < 3000; k++) begin
            p_ready = (k < 1500) ? 50 : 4;
            if (iport_enable && (o_ir || o_ie)) iport_enable = ($urandom_range(99) < 40);
            else if (iport_enable)              iport_enable = ($urandom_range(99) >= 2);
            else                                iport_enable = ($urandom_range(99) < 40);
            if (dport_enable && (o_dr || o_de)) dport_enable = ($urandom_range(99) < 40);
            else if (dport_enable)              dport_enable = ($urandom_range(99) >= 2);
            else                                dport_enable = ($urandom_range(99) < 40);
            iport_address = $urandom; iport_wr = 4'($urandom);
            dport_address = $urandom; dport_data_o = $urandom; dport_wr = 4'($urandom);
            mem_data_i = $urandom;
            mem_ready  = ($urandom_range(99) < p_ready);
            mem_error  = ($urandom_range(99) < 5);
            rst        = ($urandom_range(299) == 0);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/antares_port_arbiter.md
ANTARES_PORT_ARBITER -- requirements
Module: antares_port_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 16, bus cycles a granted transfer may wait for mem_ready before a forced error; 0 disables timeout.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 iport_address  input  32  core instruction-port address.
REQ-005 iport_wr  input  4  instruction-port byte write strobes.
REQ-006 iport_enable  input  1  instruction-port request; held high until ready or error.
REQ-007 iport_data_i  output  32  read data to instruction port.
REQ-008 iport_ready  output  1  instruction transfer complete, one cycle.
REQ-009 iport_error  output  1  instruction transfer failed, one cycle.
REQ-010 dport_address  input  32  core data-port address.
REQ-011 dport_data_o  input  32  data-port write data.
REQ-012 dport_wr  input  4  data-port byte write strobes.
REQ-013 dport_enable  input  1  data-port request; held high until ready or error.
REQ-014 dport_data_i  output  32  read data to data port.
REQ-015 dport_ready  output  1  data transfer complete, one cycle.
REQ-016 dport_error  output  1  data transfer failed, one cycle.
REQ-017 mem_address  output  32  shared single-port memory address.
REQ-018 mem_data_o  output  32  write data to memory.
REQ-019 mem_wr  output  4  byte write strobes to memory.
REQ-020 mem_enable  output  1  memory request.
REQ-021 mem_data_i  input  32  memory read data.
REQ-022 mem_ready  input  1  memory transfer complete.
REQ-023 mem_error  input  1  memory transfer failed.

Function
REQ-024 States: IDLE, BUSY_I, BUSY_D; register last_grant (I or D); timeout counter sized to hold TIMEOUT.
REQ-025 IDLE: only dport_enable -> BUSY_D; only iport_enable -> BUSY_I; both -> port not equal to last_grant; none -> stay IDLE.
REQ-026 On entering BUSY_x: last_grant <= x, counter <= 0.
REQ-027 In BUSY_x: mem_enable = x_enable; mem_address, mem_wr = granted port's; mem_data_o = dport_data_o in BUSY_D, 32'h0 otherwise; in IDLE all mem outputs 0.
REQ-028 iport_data_i and dport_data_i both = mem_data_i combinationally at all times.
REQ-029 x_ready = mem_ready in BUSY_x, else 0; x_error = mem_error in BUSY_x, else 0; same cycle, no register.
REQ-030 Completion (mem_ready or mem_error in BUSY_x): if other port's enable high -> BUSY_other next cycle (no bubble), else IDLE.
REQ-031 mem_ready and mem_error together: both forwarded; treated as single completion.
REQ-032 Timeout: counter increments each BUSY cycle without completion; when counter = TIMEOUT-1 and no completion, x_error = 1 that cycle, mem_enable forced 0 that cycle, then same transition as REQ-030.
REQ-033 Abort: x_enable low in BUSY_x without completion -> mem_enable 0, no ready/error, next state per REQ-025 evaluated with last_grant = x.
REQ-034 Minimum latency: request in IDLE at cycle n -> mem_enable at n+1 -> ready at n+1 if memory is zero-wait.
REQ-035 Ungranted port sees ready=0, error=0; its request is held, never dropped by arbiter.
REQ-036 Both ports continuously requesting -> strict alternation D, I, D, I.

Reset
REQ-037 rst high at clock edge -> state IDLE, last_grant = I, counter 0; outputs mem_enable 0, mem_wr 0, mem_address 0, mem_data_o 0, all ready/error 0 from next cycle.
REQ-038 Reset mid-transfer abandons it without ready/error; first tie after reset grants dport.

Verification
REQ-039 Single dport write 0x0000_0040, data 0xDEAD_BEEF, wr 4'hF, zero-wait memory -> mem_enable one cycle after request, dport_ready one cycle, iport_ready 0.
REQ-040 Both enables high from reset, memory ready every cycle -> grant order D, I, D, I, no IDLE cycles between transfers.
REQ-041 TIMEOUT=16, mem_ready never asserted on iport request -> iport_error high exactly in 16th BUSY_I cycle, mem_enable 0 that cycle, then IDLE.
REQ-042 mem_error with mem_ready in BUSY_D -> dport_error and dport_ready same cycle; pending iport granted next cycle.
REQ-043 dport_enable dropped in 2nd BUSY_D cycle (memory stalling) -> mem_enable 0 same cycle, no dport_ready/error, pending iport granted next cycle.
REQ-044 rst asserted during BUSY_I -> next cycle IDLE, all outputs 0; subsequent simultaneous requests grant dport first.
